seg7_reader: RTL and testbench

Receive-side counterpart of the team's hex-to-7-segment decoder: it watches a scanned, active-low 7-segment display bus (segment pattern plus per-digit enable), filters glitches, maps each stable pattern back to its 4-bit hex value, and holds one value per digit position. It sits in the smart-park test and monitoring path: it reads back what the parking display shows so counts can be checked or forwarded without tapping the counter logic.

---
 rtl/seg7_reader.sv | 185 ++++++++++++++++++
 tb/tb_seg7_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// Scanned 7-segment bus reader: synchronizes the active-low display bus, waits for a
// stable pattern, decodes it back to hex and holds one value per digit slot.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_WAIT     | key is changing / idle since reset, nothing to capture
//   S_STABLE   | key unchanged, counting towards the capture point
//   S_CAPTURE  | one cycle, capture outputs and pulses are driven
//   S_HOLD     | key unchanged after capture, no further capture
module seg7_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [6:0]            led,
  input  logic [DIGITS-1:0]     dig_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     blank,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  err
);

  localparam int KW = DIGITS + 7;
  // Counter is cleared on the cycle after the key changes, so the capture
  // point is STABLE-2 counts later to land on edge E0+STABLE+1.
  localparam logic [7:0] CNT_FIRE = 8'(STABLE - 2);

  typedef enum logic [1:0] {S_WAIT, S_STABLE, S_CAPTURE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       sync1_q, sync1_d;
  logic [KW-1:0]       key_q, key_d;
  logic [KW-1:0]       prev_q, prev_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                upd_q, upd_d;
  logic [2:0]          idx_q, idx_d;
  logic                err_q, err_d;

  logic                changed;
  logic                cap;
  logic [DIGITS-1:0]   key_dn;
  logic [6:0]          key_led;
  logic [3:0]          nlow;
  logic [4:0]          dec;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h18: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign key_dn  = key_q[KW-1:7];
  assign key_led = key_q[6:0];
  assign dec     = seg_decode(key_led);

  always_comb begin
    nlow = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nlow = nlow + {3'b000, ~key_dn[i]};
    end
  end

  always_comb begin
    sync1_d = {dig_n, led};
    key_d   = sync1_q;
    prev_d  = key_q;
    changed = (key_q != prev_q);

    if (changed)               cnt_d = 8'd0;
    else if (cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
    else                       cnt_d = cnt_q;

    cap     = 1'b0;
    state_d = state_q;
    if (changed) begin
      state_d = S_STABLE;
    end else begin
      case (state_q)
        S_WAIT:    state_d = S_WAIT;
        S_STABLE:  if (cnt_q == CNT_FIRE) begin
                     state_d = S_CAPTURE;
                     cap     = 1'b1;
                   end
        S_CAPTURE: state_d = S_HOLD;
        S_HOLD:    state_d = S_HOLD;
        default:   state_d = S_WAIT;
      endcase
    end
  end

  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    blank_d = blank_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    idx_d   = idx_q;
    if (cap) begin
      if (nlow > 4'd1) begin
        err_d = 1'b1;
      end else if (nlow == 4'd1) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!key_dn[i]) begin
            if (dec[4]) begin
              value_d[4*i +: 4] = dec[3:0];
              valid_d[i]        = 1'b1;
              blank_d[i]        = 1'b0;
              upd_d             = 1'b1;
              idx_d             = 3'(i);
            end else if (key_led == 7'h7F) begin
              value_d[4*i +: 4] = 4'h0;
              valid_d[i]        = 1'b0;
              blank_d[i]        = 1'b1;
              upd_d             = 1'b1;
              idx_d             = 3'(i);
            end else begin
              // Unmappable pattern: slot contents kept but no longer trusted.
              valid_d[i]        = 1'b0;
              blank_d[i]        = 1'b0;
              err_d             = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_WAIT;
      sync1_q <= '1;
      key_q   <= '1;
      prev_q  <= '1;
      cnt_q   <= 8'd0;
      value_q <= '0;
      valid_q <= '0;
      blank_q <= '0;
      upd_q   <= 1'b0;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      key_q   <= key_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      upd_q   <= upd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign upd         = upd_q;
  assign upd_idx     = idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed test-plan phases plus random scanning, checked by a
// sample-history reference model feeding a scoreboard queue and a negedge monitor.
module tb_seg7_reader;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int KW     = DIGITS + 7;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [6:0]          led = 7'h7F;
  logic [DIGITS-1:0]   dig_n = '1;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   blank;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                err;

  seg7_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk), .resetn(resetn), .led(led), .dig_n(dig_n),
    .value(value), .digit_valid(digit_valid), .blank(blank),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tot_upd = 0;
  int tot_err = 0;

  typedef struct {
    logic                u;
    logic                e;
    logic [2:0]          idx;
    logic [4*DIGITS-1:0] v;
    logic [DIGITS-1:0]   dv;
    logic [DIGITS-1:0]   bl;
  } ev_t;

  ev_t sbq[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [4*DIGITS-1:0] m_val;
  logic [DIGITS-1:0]   m_valid;
  logic [DIGITS-1:0]   m_blank;
  logic [KW-1:0]       hist[$];

  // A run of STABLE equal samples preceded by a different sample is captured
  // on the edge two cycles after the last sample of the run.
  task automatic model_capture(input logic [KW-1:0] k);
    logic [DIGITS-1:0] dn;
    logic [6:0]        p;
    int                nl, idx, code;
    ev_t               ev;
    dn = k[KW-1:7];
    p  = k[6:0];
    nl = 0;
    idx = 0;
    for (int i = 0; i < DIGITS; i++) if (!dn[i]) begin nl++; idx = i; end
    if (nl == 0) return;
    ev.u = 1'b0; ev.e = 1'b0; ev.idx = 3'(idx);
    if (nl > 1) begin
      ev.e = 1'b1;
    end else begin
      code = -1;
      for (int c = 0; c < 16; c++) if (seg_tab[c] == p) code = c;
      if (code >= 0) begin
        m_val[4*idx +: 4] = 4'(code); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0; ev.u = 1'b1;
      end else if (p == 7'h7F) begin
        m_val[4*idx +: 4] = 4'h0; m_valid[idx] = 1'b0; m_blank[idx] = 1'b1; ev.u = 1'b1;
      end else begin
        m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; ev.e = 1'b1;
      end
    end
    ev.v = m_val; ev.dv = m_valid; ev.bl = m_blank;
    sbq.push_back(ev);
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_val = '0; m_valid = '0; m_blank = '0;
      sbq.delete();
      hist.delete();
      for (int i = 0; i < STABLE + 2; i++) hist.push_back('1);
    end else begin : model_step
      bit run_ok;
      run_ok = (hist[0] != hist[1]);
      for (int i = 2; i <= STABLE; i++) if (hist[i] != hist[1]) run_ok = 1'b0;
      if (run_ok) model_capture(hist[1]);
      hist.push_back({dig_n, led});
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (resetn) begin : monitor
      ev_t ev;
      checks++;
      if (value !== m_val || digit_valid !== m_valid || blank !== m_blank) begin
        errors++;
        $display("FAIL slots: value=%h valid=%b blank=%b, required value=%h valid=%b blank=%b",
                 value, digit_valid, blank, m_val, m_valid, m_blank);
      end
      if (upd === 1'b1 || err === 1'b1) begin
        if (upd === 1'b1) tot_upd++;
        if (err === 1'b1) tot_err++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: upd=%b err=%b idx=%0d, required no pulse", upd, err, upd_idx);
        end else begin
          ev = sbq.pop_front();
          if (upd !== ev.u || err !== ev.e || (ev.u && upd_idx !== ev.idx)) begin
            errors++;
            $display("FAIL pulse: upd=%b err=%b idx=%0d, required upd=%b err=%b idx=%0d",
                     upd, err, upd_idx, ev.u, ev.e, ev.idx);
          end
        end
      end else if (sbq.size() != 0) begin
        ev = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: upd=0 err=0, required upd=%b err=%b idx=%0d", ev.u, ev.e, ev.idx);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [DIGITS-1:0] d, input logic [6:0] l, input int n);
    dig_n = d;
    led   = l;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_value"}, 32'(value), 32'h0);
    chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h0);
    chk({tag, "_pulses"}, {28'h0, upd, upd_idx}, 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int u0, e0, lat;
    bit found;
    logic [4*DIGITS-1:0] sv;
    logic [DIGITS-1:0] d;
    logic [6:0] p;

    repeat (3) @(negedge clk);
    chk_reset_zero("reset");
    resetn = 1'b1;

    u0 = tot_upd;
    hold(4'b1110, 7'h30, 10);
    chk("t1_upd_count", 32'(tot_upd - u0), 32'd1);
    chk("t1_value0", 32'(value[3:0]), 32'h3);
    chk("t1_valid", 32'(digit_valid), 32'b0001);

    u0 = tot_upd;
    hold(4'b1110, 7'h18, 8);
    hold(4'b1101, 7'h03, 8);
    hold(4'b1011, 7'h40, 8);
    hold(4'b0111, 7'h0E, 8);
    hold(4'b1111, 7'h7F, 10);
    chk("t2_upd_count", 32'(tot_upd - u0), 32'd4);
    chk("t2_value", 32'(value), 32'hF0B9);
    chk("t2_valid", 32'(digit_valid), 32'b1111);

    u0 = tot_upd; e0 = tot_err;
    hold(4'b1011, 7'h24, 10);
    hold(4'b1011, 7'h7F, 2);
    hold(4'b1011, 7'h24, 10);
    chk("t3_upd_count", 32'(tot_upd - u0), 32'd2);
    chk("t3_err_count", 32'(tot_err - e0), 32'd0);
    chk("t3_value2", 32'(value[11:8]), 32'h2);

    hold(4'b1101, 7'h7F, 10);
    chk("t4_blank", 32'(blank), 32'b0010);
    chk("t4_valid1", 32'(digit_valid[1]), 32'd0);
    chk("t4_value1", 32'(value[7:4]), 32'h0);
    u0 = tot_upd; e0 = tot_err;
    hold(4'b1101, 7'h55, 10);
    chk("t4_err_count", 32'(tot_err - e0), 32'd1);
    chk("t4_upd_count", 32'(tot_upd - u0), 32'd0);
    chk("t4_blank1", 32'(blank[1]), 32'd0);

    sv = value; e0 = tot_err;
    hold(4'b1100, 7'h12, 10);
    chk("t5_multi_err", 32'(tot_err - e0), 32'd1);
    chk("t5_value_kept", 32'(value), 32'(sv));
    u0 = tot_upd; e0 = tot_err;
    hold(4'b1111, 7'h12, 10);
    chk("t5_idle_pulses", 32'(tot_upd - u0 + tot_err - e0), 32'd0);

    dig_n = 4'b1110; led = 7'h30;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #2 chk_reset_zero("midreset");
    @(posedge clk);
    #1 resetn = 1'b1;
    lat = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      lat++;
      #1 if (upd === 1'b1) found = 1'b1;
    end
    chk("t6_capture_found", 32'(found), 32'd1);
    chk("t6_latency_edges", 32'(lat), 32'd6);
    @(negedge clk);

    for (int s = 0; s < 300; s++) begin
      int r, i1, i2;
      r = $urandom_range(0, 9);
      d = '1;
      if (r < 7) begin
        d[$urandom_range(0, DIGITS-1)] = 1'b0;
      end else if (r == 8) begin
        i1 = $urandom_range(0, DIGITS-1);
        i2 = (i1 + 1 + $urandom_range(0, DIGITS-2)) % DIGITS;
        d[i1] = 1'b0; d[i2] = 1'b0;
      end else if (r == 9) begin
        d = DIGITS'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7)       p = seg_tab[$urandom_range(0, 15)];
      else if (r == 7) p = 7'h7F;
      else             p = 7'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
      hold(d, p, $urandom_range(1, 12));
    end

    hold('1, 7'h7F, 20);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
